// File: rtl/faddr.sv
// faddr: one-bit full adder with a registered capture stage
// and a saturating carry-event counter for observability.
module faddr #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             X,
    input  logic             Y,
    input  logic             Z,
    input  logic             en,
    output logic             S,
    output logic             C,
    output logic             S_q,
    output logic             C_q,
    output logic             vld,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sum_d;
    logic             sum_q;
    logic             carry_d;
    logic             carry_q;
    logic             vld_d;
    logic             vld_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Pure combinational adder; no dependence on clk, rst_n or en.
    always_comb begin
        S = X ^ Y ^ Z;
        C = (X & Y) | (X & Z) | (Y & Z);
    end

    // Next-state for the capture stage and the saturating counter.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        vld_d   = 1'b0;
        cnt_d   = cnt_q;
        if (en) begin
            sum_d   = S;
            carry_d = C;
            vld_d   = 1'b1;
            if (C && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drive registered outputs from the flops.
    always_comb begin
        S_q       = sum_q;
        C_q       = carry_q;
        vld       = vld_q;
        carry_cnt = cnt_q;
    end

endmodule

// File: tb/tb_faddr.sv
// tb_faddr: directed self-checking bench for faddr.
// Clock edges are produced on demand by the tick task.
module tb_faddr;

    logic       clk;
    logic       rst_n;
    logic       X;
    logic       Y;
    logic       Z;
    logic       en;
    logic       S;
    logic       C;
    logic       S_q;
    logic       C_q;
    logic       vld;
    logic [7:0] carry_cnt;

    int checks;
    int errors;

    faddr #(.CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .X         (X),
        .Y         (Y),
        .Z         (Z),
        .en        (en),
        .S         (S),
        .C         (C),
        .S_q       (S_q),
        .C_q       (C_q),
        .vld       (vld),
        .carry_cnt (carry_cnt)
    );

    task automatic tick();
        #5 clk = 1'b1;
        #5 clk = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic s_e,
                           input logic c_e, input logic v_e,
                           input logic [7:0] n_e);
        chk({tag, ".S_q"}, 32'(S_q), 32'(s_e));
        chk({tag, ".C_q"}, 32'(C_q), 32'(c_e));
        chk({tag, ".vld"}, 32'(vld), 32'(v_e));
        chk({tag, ".cnt"}, 32'(carry_cnt), 32'(n_e));
    endtask

    logic [1:0] cs_tab [8];
    logic [7:0] cnt_tab [8];

    initial begin
        checks = 0;
        errors = 0;
        cs_tab  = '{2'b00, 2'b01, 2'b01, 2'b10,
                    2'b01, 2'b10, 2'b10, 2'b11};
        cnt_tab = '{8'd1, 8'd1, 8'd1, 8'd2,
                    8'd2, 8'd3, 8'd4, 8'd5};
        clk   = 1'b0;
        rst_n = 1'b0;
        en    = 1'b0;
        {X, Y, Z} = 3'b000;

        // combinational sweep, clock idle
        for (int i = 0; i < 8; i++) begin
            {X, Y, Z} = 3'(i);
            #10;
            chk($sformatf("comb%0d.S", i), 32'(S), 32'(cs_tab[i][0]));
            chk($sformatf("comb%0d.C", i), 32'(C), 32'(cs_tab[i][1]));
        end
        chk_reg("por", 1'b0, 1'b0, 1'b0, 8'd0);

        // release, capture, then asynchronous reset between edges
        #3 rst_n = 1'b1;
        en = 1'b1;
        {X, Y, Z} = 3'b101;
        tick();
        chk_reg("cap101", 1'b0, 1'b1, 1'b1, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reg("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
        chk("rst.S", 32'(S), 32'd0);
        chk("rst.C", 32'(C), 32'd1);
        {X, Y, Z} = 3'b100;
        #1;
        chk("rst.S2", 32'(S), 32'd1);
        chk("rst.C2", 32'(C), 32'd0);
        #1 rst_n = 1'b1;

        // capture then hold
        en = 1'b1;
        {X, Y, Z} = 3'b111;
        tick();
        chk_reg("cap111", 1'b1, 1'b1, 1'b1, 8'd1);
        en = 1'b0;
        {X, Y, Z} = 3'b000;
        tick();
        chk_reg("hold", 1'b1, 1'b1, 1'b0, 8'd1);

        // carry counting over all combinations
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {X, Y, Z} = 3'(i);
            tick();
            chk($sformatf("sweep%0d.cnt", i),
                32'(carry_cnt), 32'(cnt_tab[i]));
        end
        chk_reg("sweep_end", 1'b1, 1'b1, 1'b1, 8'd5);

        // saturation: 5 + 300 carries clamps at 255
        {X, Y, Z} = 3'b110;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (i == 248)
                chk("sat_m1", 32'(carry_cnt), 32'd254);
            if (i == 249)
                chk("sat_hit", 32'(carry_cnt), 32'd255);
        end
        chk_reg("sat_end", 1'b0, 1'b1, 1'b1, 8'd255);

        // reset mid-run with en=1 and C=1
        {X, Y, Z} = 3'b111;
        #2 rst_n = 1'b0;
        #1;
        chk_reg("mid_rst", 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        chk_reg("rst_edge", 1'b0, 1'b0, 1'b0, 8'd0);
        #2 rst_n = 1'b1;
        {X, Y, Z} = 3'b011;
        tick();
        chk_reg("post_rst", 1'b0, 1'b1, 1'b1, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
